// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W    = 24;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_MAX_BURST = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_C = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // One requester's beat request at the default widths.
    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle: master is the requester, slave is the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/arb_beat_counter.sv
// Saturating beat counter; at_limit_o flags that the next beat is the last one allowed.
module arb_beat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             at_limit_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit_q, at_limit_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Registered look-ahead: one beat from the limit, or already saturated.
        at_limit_d = (cnt_d >= (limit_i - CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign at_limit_o = at_limit_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Core/DMA arbiter for a single memory port with burst-limited preemption.
// Define ARB_ROUND_ROBIN_EN for fair IDLE tie-breaks and preemption of both owners.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  c_if,
    mem_port_arbiter_if.slave  d_if,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_we,
    input  logic [DATA_W-1:0]  mem_rdata
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e state_q, state_d;
    logic       c_rvalid_q, c_rvalid_d;
    logic       d_rvalid_q, d_rvalid_d;
    logic       c_beat, d_beat;
    logic       at_limit;
    logic       d_wins_tie;
    logic       c_preempt_en;

    assign c_beat = (state_q == OWN_C) && c_if.req;
    assign d_beat = (state_q == OWN_D) && d_if.req;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner_q;

    assign d_wins_tie   = (last_owner_q == OWNER_C);
    assign c_preempt_en = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWNER_C;
        end else if (state_d == OWN_C) begin
            last_owner_q <= OWNER_C;
        end else if (state_d == OWN_D) begin
            last_owner_q <= OWNER_D;
        end
    end
`else
    assign d_wins_tie   = 1'b0;
    assign c_preempt_en = 1'b0;
`endif

    // Next-state: owner hand-off happens directly, never through IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (c_if.req && d_if.req) begin
                    state_d = d_wins_tie ? OWN_D : OWN_C;
                end else if (c_if.req) begin
                    state_d = OWN_C;
                end else if (d_if.req) begin
                    state_d = OWN_D;
                end
            end
            OWN_C: begin
                if (!c_if.req) begin
                    state_d = d_if.req ? OWN_D : IDLE;
                end else if (d_if.req && at_limit && c_preempt_en) begin
                    state_d = OWN_D;
                end
            end
            OWN_D: begin
                if (!d_if.req) begin
                    state_d = c_if.req ? OWN_C : IDLE;
                end else if (c_if.req && at_limit) begin
                    state_d = OWN_C;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign c_rvalid_d = c_beat & ~c_if.we;
    assign d_rvalid_d = d_beat & ~d_if.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    arb_beat_counter #(
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_d != state_q),
        .inc_i      (c_beat | d_beat),
        .limit_i    (CNT_W'(MAX_BURST)),
        .at_limit_o (at_limit)
    );

    // Memory port mux: zero whenever no beat is in progress.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (c_beat) begin
            mem_addr  = c_if.addr;
            mem_wdata = c_if.wdata;
            mem_we    = c_if.we;
        end else if (d_beat) begin
            mem_addr  = d_if.addr;
            mem_wdata = d_if.wdata;
            mem_we    = d_if.we;
        end
    end

    assign c_if.gnt    = c_beat;
    assign d_if.gnt    = d_beat;
    assign c_if.rvalid = c_rvalid_q;
    assign d_if.rvalid = d_rvalid_q;
    assign c_if.rdata  = c_rvalid_q ? mem_rdata : '0;
    assign d_if.rdata  = d_rvalid_q ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized traffic.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;
    localparam int MB = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c_bus ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_if      (c_bus),
        .d_if      (d_bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Environment memory: synchronous read, data valid the cycle after the address.
    logic [DW-1:0] env_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr[7:0]];
    end

    typedef struct packed {
        logic          c_gnt;
        logic          d_gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cyc_exp_t;

    typedef struct {
        bit            who_d;
        logic [DW-1:0] data;
        int unsigned   due;
    } rd_exp_t;

    cyc_exp_t      exp_cyc[$];
    rd_exp_t       exp_rd[$];
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    int            owner;   // 0 none, 1 core, 2 dma
    int            beats;
    int            last;
    int unsigned   cyc = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic arb_req_t mk(input bit req, input bit we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] wd);
        arb_req_t r;
        r.req = req; r.we = we; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    function automatic arb_req_t rnd_req(input bit req);
        logic [AW-1:0] a;
        a = {8'($urandom_range(0, 3)), 8'h00, 8'($urandom_range(0, 15))};
        return mk(req, ($urandom_range(0, 2) == 0), a, 16'($urandom));
    endfunction

    task automatic model_reset();
        owner = 0;
        beats = 0;
        last  = 1;
        exp_rd.delete();
    endtask

    // One cycle: apply inputs, predict this cycle's outputs, advance the reference arbiter.
    task automatic drive(input bit rst, input arb_req_t c, input arb_req_t d);
        cyc_exp_t e;
        rd_exp_t  r;
        int       nxt, after;
        bit       mine, other, pre_ok;
        @(posedge clk);
        #1;
        cyc++;
        rst_n       = rst;
        c_bus.req   = c.req;  c_bus.we = c.we;  c_bus.addr = c.addr;  c_bus.wdata = c.wdata;
        d_bus.req   = d.req;  d_bus.we = d.we;  d_bus.addr = d.addr;  d_bus.wdata = d.wdata;
        e = '0;
        if (!rst) begin
            model_reset();
        end else begin
            if (owner == 1 && c.req) begin
                e.c_gnt = 1'b1; e.we = c.we; e.addr = c.addr; e.wdata = c.wdata;
            end else if (owner == 2 && d.req) begin
                e.d_gnt = 1'b1; e.we = d.we; e.addr = d.addr; e.wdata = d.wdata;
            end
            if (e.c_gnt || e.d_gnt) begin
                if (e.we) begin
                    ref_mem[e.addr[7:0]] = e.wdata;
                end else begin
                    r.who_d = e.d_gnt;
                    r.data  = ref_mem[e.addr[7:0]];
                    r.due   = cyc + 1;
                    exp_rd.push_back(r);
                end
            end
            nxt   = owner;
            after = 0;
            if (owner == 0) begin
                if (c.req && d.req) nxt = (RR && last == 1) ? 2 : 1;
                else if (c.req)     nxt = 1;
                else if (d.req)     nxt = 2;
            end else begin
                mine   = (owner == 1) ? c.req : d.req;
                other  = (owner == 1) ? d.req : c.req;
                pre_ok = RR || (owner == 2);
                after  = beats + (mine ? 1 : 0);
                if (after > MB) after = MB;
                if (!mine)                                  nxt = other ? 3 - owner : 0;
                else if (other && pre_ok && after == MB)    nxt = 3 - owner;
            end
            if (nxt != owner) begin
                beats = 0;
                if (nxt != 0) last = nxt;
            end else begin
                beats = after;
            end
            owner = nxt;
        end
        exp_cyc.push_back(e);
    endtask

    // Reset asserted in the middle of the cycle already driven.
    task automatic async_reset_now();
        cyc_exp_t z;
        z = '0;
        #1;
        rst_n = 1'b0;
        void'(exp_cyc.pop_back());
        exp_cyc.push_back(z);
        model_reset();
        #1;
        chk("async_reset_outputs",
            64'({c_bus.gnt, d_bus.gnt, c_bus.rvalid, d_bus.rvalid, c_bus.rdata, d_bus.rdata,
                 mem_we, mem_addr, mem_wdata}), 64'(0));
    endtask

    // Monitor: compares DUT outputs against the queued predictions every cycle.
    initial begin
        cyc_exp_t      e;
        rd_exp_t       r;
        bit            ecv, edv;
        logic [DW-1:0] ecd, edd;
        forever begin
            @(negedge clk);
            checks++;
            a_mutex: assert (!(c_bus.gnt && d_bus.gnt)) else begin
                errors++;
                $display("FAIL mutex: c_gnt=%0b d_gnt=%0b expected not both (cycle %0d)",
                         c_bus.gnt, d_bus.gnt, cyc);
            end
            if (exp_cyc.size() == 0) continue;
            e = exp_cyc.pop_front();
            chk("c_gnt", 64'(c_bus.gnt), 64'(e.c_gnt));
            chk("d_gnt", 64'(d_bus.gnt), 64'(e.d_gnt));
            chk("mem_port", 64'({mem_we, mem_addr, mem_wdata}), 64'({e.we, e.addr, e.wdata}));
            ecv = 1'b0; edv = 1'b0; ecd = '0; edd = '0;
            if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
                r = exp_rd.pop_front();
                if (r.who_d) begin edv = 1'b1; edd = r.data; end
                else         begin ecv = 1'b1; ecd = r.data; end
            end
            chk("c_read", 64'({c_bus.rvalid, c_bus.rdata}), 64'({ecv, ecd}));
            chk("d_read", 64'({d_bus.rvalid, d_bus.rdata}), 64'({edv, edd}));
        end
    end

    initial begin
        arb_req_t idle, c, d;
        bit       cr, dr, rst;
        int       d_beats, first_c;
        idle = '0;
        rst_n = 1'b0;
        c_bus.req = 1'b0; c_bus.we = 1'b0; c_bus.addr = '0; c_bus.wdata = '0;
        d_bus.req = 1'b0; d_bus.we = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
        model_reset();

        drive(1'b0, idle, mk(1, 0, 24'h000005, 16'h0));
        drive(1'b0, idle, mk(1, 0, 24'h000005, 16'h0));
        #1 chk("reset_outputs",
               64'({c_bus.gnt, d_bus.gnt, c_bus.rvalid, d_bus.rvalid, mem_we, mem_addr, mem_wdata}),
               64'(0));

        // Seed address 5, then reset and read it back with the documented latency.
        d = mk(1, 1, 24'h000005, 16'h1234);
        drive(1'b1, idle, d);
        drive(1'b1, idle, d);
        drive(1'b1, idle, idle);
        drive(1'b0, idle, idle);
        drive(1'b0, idle, idle);
        c = mk(1, 0, 24'h000005, 16'h0);
        drive(1'b1, c, idle);
        #1 chk("first_cycle_no_gnt", 64'(c_bus.gnt), 64'(0));
        drive(1'b1, c, idle);
        #1 chk("second_cycle_gnt", 64'(c_bus.gnt), 64'(1));
        drive(1'b1, idle, idle);
        #1 chk("read_return", 64'({c_bus.rvalid, c_bus.rdata}), 64'({1'b1, 16'h1234}));

        // Core write beat.
        c = mk(1, 1, 24'h010020, 16'hBEEF);
        drive(1'b1, c, idle);
        drive(1'b1, c, idle);
        #1 chk("write_beat", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 24'h010020, 16'hBEEF}));
        drive(1'b1, idle, idle);
        #1 chk("write_no_rvalid", 64'(c_bus.rvalid), 64'(0));
        drive(1'b1, idle, idle);

        // DMA burst preempted by the core after MAX_BURST beats.
        d_beats = 0;
        first_c = -1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i >= 3) ? mk(1, 0, 24'h000007, 16'h0) : idle,
                  mk(1, 0, 24'(i), 16'h0));
            #1;
            if (first_c < 0) begin
                if (c_bus.gnt) begin
                    first_c = i;
                    chk("dgnt_at_handoff", 64'(d_bus.gnt), 64'(0));
                end else if (d_bus.gnt) begin
                    d_beats++;
                end
            end
        end
        chk("dma_burst_len", 64'(d_beats), 64'(MB));
        chk("core_first_gnt_cycle", 64'(first_c), 64'(MB + 1));
        drive(1'b1, idle, idle);
        drive(1'b1, idle, idle);

        // Simultaneous requests from IDLE straight after reset.
        drive(1'b0, idle, idle);
        drive(1'b1, mk(1, 0, 24'h000001, 16'h0), mk(1, 0, 24'h000002, 16'h0));
        drive(1'b1, mk(1, 0, 24'h000001, 16'h0), mk(1, 0, 24'h000002, 16'h0));
        #1 chk("tie_winner", 64'({c_bus.gnt, d_bus.gnt}), RR ? 64'(2'b01) : 64'(2'b10));
        drive(1'b1, idle, idle);
        drive(1'b1, idle, idle);

        // Reset mid DMA read beat.
        d = mk(1, 0, 24'h000003, 16'h0);
        drive(1'b1, idle, d);
        drive(1'b1, idle, d);
        #1 chk("dma_beat_before_reset", 64'(d_bus.gnt), 64'(1));
        async_reset_now();
        drive(1'b0, idle, d);
        drive(1'b1, idle, d);
        #1 chk("after_release", 64'({d_bus.gnt, d_bus.rvalid}), 64'(0));
        drive(1'b1, idle, d);
        #1 chk("after_release_gnt", 64'(d_bus.gnt), 64'(1));
        drive(1'b1, idle, idle);
        drive(1'b1, idle, idle);

        // Randomized traffic with occasional resets.
        cr = 1'b0;
        dr = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 3) == 0) cr = ~cr;
            if ($urandom_range(0, 3) == 0) dr = ~dr;
            c = rnd_req(cr);
            d = rnd_req(dr);
            drive(rst, c, d);
            if (!rst) drive(1'b0, c, d);
        end
        drive(1'b1, idle, idle);
        drive(1'b1, idle, idle);
        drive(1'b1, idle, idle);
        @(negedge clk);
        #1 chk("reads_drained", 64'(exp_rd.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
